// File: rtl/uc_coordena_pkg.sv
// Shared state codes and default table sizes for the asteroid/shot sweep.
// Ship collision check is enabled with UC_COORDENA_COLISAO_NAVE_EN.
package uc_coordena_pkg;

  localparam int N_ASTEROIDES_PADRAO = 16;
  localparam int N_TIROS_PADRAO      = 8;

  localparam logic [4:0] ESTADO_OCIOSO       = 5'h00;
  localparam logic [4:0] ESTADO_PREPARA      = 5'h01;
  localparam logic [4:0] ESTADO_LE_AST       = 5'h02;
  localparam logic [4:0] ESTADO_ATUALIZA_AST = 5'h03;
  localparam logic [4:0] ESTADO_CHECA_NAVE   = 5'h04;
  localparam logic [4:0] ESTADO_PROX_AST     = 5'h05;
  localparam logic [4:0] ESTADO_LE_TIRO      = 5'h06;
  localparam logic [4:0] ESTADO_ATUALIZA_TIRO = 5'h07;
  localparam logic [4:0] ESTADO_LE_ALVO      = 5'h08;
  localparam logic [4:0] ESTADO_CHECA_ALVO   = 5'h09;
  localparam logic [4:0] ESTADO_PROX_ALVO    = 5'h0A;
  localparam logic [4:0] ESTADO_PROX_TIRO    = 5'h0B;
  localparam logic [4:0] ESTADO_CONCLUIDO    = 5'h0C;
  localparam logic [4:0] ESTADO_ERRO         = 5'h0F;

  typedef enum logic [4:0] {
    OCIOSO        = ESTADO_OCIOSO,
    PREPARA       = ESTADO_PREPARA,
    LE_AST        = ESTADO_LE_AST,
    ATUALIZA_AST  = ESTADO_ATUALIZA_AST,
    CHECA_NAVE    = ESTADO_CHECA_NAVE,
    PROX_AST      = ESTADO_PROX_AST,
    LE_TIRO       = ESTADO_LE_TIRO,
    ATUALIZA_TIRO = ESTADO_ATUALIZA_TIRO,
    LE_ALVO       = ESTADO_LE_ALVO,
    CHECA_ALVO    = ESTADO_CHECA_ALVO,
    PROX_ALVO     = ESTADO_PROX_ALVO,
    PROX_TIRO     = ESTADO_PROX_TIRO,
    CONCLUIDO     = ESTADO_CONCLUIDO,
    ERRO          = ESTADO_ERRO
  } estado_t;

endpackage

// File: rtl/uc_coordena_asteroides_tiros_contador.sv
// Sweep index counter: clear, increment modulo 2^W, last-entry flag.
// Used for the asteroid, shot and target indices.
module contador_varredura #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] valor,
  output logic         ultimo
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valor <= '0;
    end else if (zera) begin
      valor <= '0;
    end else if (conta) begin
      valor <= valor + 1'b1;
    end
  end

  assign ultimo = &valor;

endmodule

// File: rtl/uc_coordena_asteroides_tiros.sv
// Movement sweep control unit: asteroid table, then shot table vs targets.
// Ship collision check is enabled with UC_COORDENA_COLISAO_NAVE_EN.
module uc_coordena_asteroides_tiros
  import uc_coordena_pkg::*;
#(
  parameter int N_ASTEROIDES = N_ASTEROIDES_PADRAO,
  parameter int N_TIROS      = N_TIROS_PADRAO
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            iniciar,
  input  logic                            vidas,
  input  logic                            asteroide_ativo,
  input  logic                            tiro_ativo,
  input  logic                            colisao_nave,
  input  logic                            colisao_tiro,
  output logic [$clog2(N_ASTEROIDES)-1:0] addr_asteroide,
  output logic [$clog2(N_TIROS)-1:0]      addr_tiro,
  output logic                            mover_asteroide,
  output logic                            mover_tiro,
  output logic                            apaga_asteroide,
  output logic                            apaga_tiro,
  output logic                            decrementa_vidas,
  output logic                            incrementa_pontos,
  output logic                            pronto,
  output logic [4:0]                      db_estado
);

  localparam int WA = $clog2(N_ASTEROIDES);
  localparam int WT = $clog2(N_TIROS);

  estado_t estado, proximo;

  logic          zera_i, conta_i, ult_i;
  logic          zera_t, conta_t, ult_t;
  logic          zera_j, conta_j, ult_j;
  logic [WA-1:0] val_i, val_j;
  logic [WT-1:0] val_t;
  logic          em_alvo;

`ifndef UC_COORDENA_COLISAO_NAVE_EN
  logic nave_unused;
  assign nave_unused = colisao_nave;
`endif

  contador_varredura #(.W(WA)) u_cnt_i (
    .clock  (clock),
    .reset_n(reset_n),
    .zera   (zera_i),
    .conta  (conta_i),
    .valor  (val_i),
    .ultimo (ult_i)
  );

  contador_varredura #(.W(WT)) u_cnt_t (
    .clock  (clock),
    .reset_n(reset_n),
    .zera   (zera_t),
    .conta  (conta_t),
    .valor  (val_t),
    .ultimo (ult_t)
  );

  contador_varredura #(.W(WA)) u_cnt_j (
    .clock  (clock),
    .reset_n(reset_n),
    .zera   (zera_j),
    .conta  (conta_j),
    .valor  (val_j),
    .ultimo (ult_j)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo;
    end
  end

  always_comb begin
    proximo           = estado;
    zera_i            = 1'b0;
    zera_t            = 1'b0;
    zera_j            = 1'b0;
    conta_i           = 1'b0;
    conta_t           = 1'b0;
    conta_j           = 1'b0;
    mover_asteroide   = 1'b0;
    mover_tiro        = 1'b0;
    apaga_asteroide   = 1'b0;
    apaga_tiro        = 1'b0;
    decrementa_vidas  = 1'b0;
    incrementa_pontos = 1'b0;
    pronto            = 1'b0;
    unique case (estado)
      OCIOSO: begin
        {zera_i, zera_t, zera_j} = 3'b111;
        if (iniciar) proximo = PREPARA;
      end
      PREPARA: begin
        {zera_i, zera_t, zera_j} = 3'b111;
        proximo = vidas ? LE_AST : CONCLUIDO;
      end
      LE_AST: proximo = ATUALIZA_AST;
      ATUALIZA_AST: begin
        mover_asteroide = asteroide_ativo;
`ifdef UC_COORDENA_COLISAO_NAVE_EN
        proximo = CHECA_NAVE;
`else
        proximo = PROX_AST;
`endif
      end
`ifdef UC_COORDENA_COLISAO_NAVE_EN
      CHECA_NAVE: begin
        if (asteroide_ativo && colisao_nave) begin
          apaga_asteroide  = 1'b1;
          decrementa_vidas = 1'b1;
        end
        proximo = PROX_AST;
      end
`endif
      PROX_AST: begin
        if (ult_i) begin
          proximo = LE_TIRO;
        end else begin
          conta_i = 1'b1;
          proximo = LE_AST;
        end
      end
      LE_TIRO: proximo = ATUALIZA_TIRO;
      ATUALIZA_TIRO: begin
        if (tiro_ativo) begin
          mover_tiro = 1'b1;
          zera_j     = 1'b1;
          proximo    = LE_ALVO;
        end else begin
          proximo = PROX_TIRO;
        end
      end
      LE_ALVO: proximo = CHECA_ALVO;
      CHECA_ALVO: begin
        // A shot is consumed by its first hit.
        if (asteroide_ativo && tiro_ativo && colisao_tiro) begin
          apaga_asteroide   = 1'b1;
          apaga_tiro        = 1'b1;
          incrementa_pontos = 1'b1;
          proximo           = PROX_TIRO;
        end else begin
          proximo = PROX_ALVO;
        end
      end
      PROX_ALVO: begin
        if (ult_j) begin
          proximo = PROX_TIRO;
        end else begin
          conta_j = 1'b1;
          proximo = LE_ALVO;
        end
      end
      PROX_TIRO: begin
        if (ult_t) begin
          proximo = CONCLUIDO;
        end else begin
          conta_t = 1'b1;
          proximo = LE_TIRO;
        end
      end
      CONCLUIDO: begin
        pronto = 1'b1;
        {zera_i, zera_t, zera_j} = 3'b111;
        if (iniciar) proximo = PREPARA;
      end
      ERRO:    proximo = OCIOSO;
      default: proximo = ERRO;
    endcase
  end

  assign em_alvo = (estado == LE_ALVO) ||
                   (estado == CHECA_ALVO) ||
                   (estado == PROX_ALVO);

  assign addr_asteroide = em_alvo ? val_j : val_i;
  assign addr_tiro      = val_t;
  assign db_estado      = estado;

endmodule

// File: tb/tb_uc_coordena_asteroides_tiros.sv
// Directed bench for the sweep control unit with a registered-read table model.
// Expected timing follows UC_COORDENA_COLISAO_NAVE_EN when defined.
module tb_uc_coordena_asteroides_tiros;

  localparam int NA = 16;
  localparam int NT = 8;
`ifdef UC_COORDENA_COLISAO_NAVE_EN
  localparam int CA   = 4;
  localparam int NAVE = 1;
`else
  localparam int CA   = 3;
  localparam int NAVE = 0;
`endif
  localparam int BASE = 1 + CA * NA + 3 * NT;

  logic       clock;
  logic       reset_n;
  logic       iniciar;
  logic       vidas;
  logic       asteroide_ativo;
  logic       tiro_ativo;
  logic       colisao_nave;
  logic       colisao_tiro;
  logic [3:0] addr_asteroide;
  logic [2:0] addr_tiro;
  logic       mover_asteroide;
  logic       mover_tiro;
  logic       apaga_asteroide;
  logic       apaga_tiro;
  logic       decrementa_vidas;
  logic       incrementa_pontos;
  logic       pronto;
  logic [4:0] db_estado;

  uc_coordena_asteroides_tiros #(
    .N_ASTEROIDES(NA),
    .N_TIROS     (NT)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .iniciar          (iniciar),
    .vidas            (vidas),
    .asteroide_ativo  (asteroide_ativo),
    .tiro_ativo       (tiro_ativo),
    .colisao_nave     (colisao_nave),
    .colisao_tiro     (colisao_tiro),
    .addr_asteroide   (addr_asteroide),
    .addr_tiro        (addr_tiro),
    .mover_asteroide  (mover_asteroide),
    .mover_tiro       (mover_tiro),
    .apaga_asteroide  (apaga_asteroide),
    .apaga_tiro       (apaga_tiro),
    .decrementa_vidas (decrementa_vidas),
    .incrementa_pontos(incrementa_pontos),
    .pronto           (pronto),
    .db_estado        (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [NA-1:0] ast_mem;
  logic [NA-1:0] nave_mem;
  logic [NT-1:0] tiro_mem;
  int            hit_a;
  int            hit_t;

  // Tables answer one cycle after the address is presented.
  always @(posedge clock) begin
    asteroide_ativo <= ast_mem[addr_asteroide];
    colisao_nave    <= nave_mem[addr_asteroide];
    tiro_ativo      <= tiro_mem[addr_tiro];
    colisao_tiro    <= (int'(addr_asteroide) == hit_a) &&
                       (int'(addr_tiro) == hit_t);
  end

  int n_chk;
  int n_fail;
  int n_ma, a_ma, c_ma;
  int n_aa, a_aa, c_aa;
  int n_dec, n_mt, a_mt;
  int n_at, a_at, n_inc;
  int n_alvo, max_j, n_le;
  int ciclos;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int strobes();
    return int'({mover_asteroide, mover_tiro, apaga_asteroide,
                 apaga_tiro, decrementa_vidas, incrementa_pontos});
  endfunction

  task automatic varre();
    bit ok;
    n_ma = 0; a_ma = -1; c_ma = -1;
    n_aa = 0; a_aa = -1; c_aa = -1;
    n_dec = 0; n_mt = 0; a_mt = -1;
    n_at = 0; a_at = -1; n_inc = 0;
    n_alvo = 0; max_j = -1; n_le = 0;
    ciclos = 0;
    ok = 1'b0;
    iniciar = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (db_estado == 5'd1) begin
        ok = 1'b1;
        break;
      end
    end
    iniciar = 1'b0;
    if (!ok) begin
      chk("prepara_timeout", 0, 1);
      return;
    end
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      ciclos++;
      if (mover_asteroide) begin
        n_ma++; a_ma = int'(addr_asteroide); c_ma = ciclos;
      end
      if (apaga_asteroide) begin
        n_aa++; a_aa = int'(addr_asteroide); c_aa = ciclos;
      end
      if (decrementa_vidas) n_dec++;
      if (mover_tiro) begin
        n_mt++; a_mt = int'(addr_tiro);
      end
      if (apaga_tiro) begin
        n_at++; a_at = int'(addr_tiro);
      end
      if (incrementa_pontos) n_inc++;
      if (db_estado == 5'd8) begin
        n_alvo++;
        if (int'(addr_asteroide) > max_j) max_j = int'(addr_asteroide);
      end
      if (db_estado == 5'd2 || db_estado == 5'd6 ||
          db_estado == 5'd8) n_le++;
      if (pronto) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("pronto_timeout", 0, 1);
  endtask

  initial begin
    bit ok;
    n_chk = 0;
    n_fail = 0;
    reset_n = 1'b0;
    iniciar = 1'b0;
    vidas = 1'b1;
    ast_mem = '0;
    nave_mem = '0;
    tiro_mem = '0;
    hit_a = -1;
    hit_t = -1;
    repeat (3) @(negedge clock);
    chk("rst_estado", int'(db_estado), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_strobes", strobes(), 0);
    reset_n = 1'b1;

    // Reset in the middle of the shot sweep
    tiro_mem = 8'h01;
    @(negedge clock);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clock);
      if (db_estado == 5'd7) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_state7", int'(ok), 1);
    chk("pre_rst_mover_tiro", int'(mover_tiro), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_estado", int'(db_estado), 0);
    chk("mid_rst_strobes", strobes(), 0);
    chk("mid_rst_pronto", int'(pronto), 0);
    chk("mid_rst_addr_a", int'(addr_asteroide), 0);
    chk("mid_rst_addr_t", int'(addr_tiro), 0);
    @(negedge clock);
    chk("mid_rst_hold", strobes(), 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_idle", int'(db_estado), 0);

    // All entries inactive
    tiro_mem = '0;
    varre();
    chk("vazio_ciclos", ciclos, BASE);
    chk("vazio_strobes",
        n_ma + n_aa + n_dec + n_mt + n_at + n_inc, 0);
    chk("vazio_leituras", n_le, NA + NT);
    chk("vazio_estado", int'(db_estado), 12);

    // Request held high while done
    iniciar = 1'b1;
    @(negedge clock);
    chk("rearm_estado", int'(db_estado), 1);
    chk("rearm_pronto", int'(pronto), 0);
    chk("rearm_addr_a", int'(addr_asteroide), 0);
    chk("rearm_addr_t", int'(addr_tiro), 0);
    @(negedge clock);
    chk("rearm_le_ast", int'(db_estado), 2);
    iniciar = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clock);
      if (pronto) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rearm_done", int'(ok), 1);

    // No lives left
    vidas = 1'b0;
    varre();
    chk("sem_vidas_ciclos", ciclos, 1);
    chk("sem_vidas_leituras", n_le, 0);
    vidas = 1'b1;

    // Asteroid 5 hits the ship
    ast_mem = 16'h0020;
    nave_mem = 16'h0020;
    varre();
    chk("nave_n_mover", n_ma, 1);
    chk("nave_addr_mover", a_ma, 5);
    chk("nave_ciclo_mover", c_ma, 2 + CA * 5);
    chk("nave_n_apaga", n_aa, NAVE);
    chk("nave_n_dec", n_dec, NAVE);
    if (NAVE == 1) begin
      chk("nave_addr_apaga", a_aa, 5);
      chk("nave_ciclo_apaga", c_aa, c_ma + 1);
    end
    chk("nave_ciclos", ciclos, BASE);

    // Shot 2 hits asteroid 9
    ast_mem = 16'h0200;
    nave_mem = '0;
    tiro_mem = 8'h04;
    hit_a = 9;
    hit_t = 2;
    varre();
    chk("tiro_n_mover_a", n_ma, 1);
    chk("tiro_n_mover_t", n_mt, 1);
    chk("tiro_addr_mover_t", a_mt, 2);
    chk("tiro_n_alvo", n_alvo, 10);
    chk("tiro_max_j", max_j, 9);
    chk("tiro_n_apaga_a", n_aa, 1);
    chk("tiro_addr_apaga_a", a_aa, 9);
    chk("tiro_n_apaga_t", n_at, 1);
    chk("tiro_addr_apaga_t", a_at, 2);
    chk("tiro_n_inc", n_inc, 1);
    chk("tiro_n_dec", n_dec, 0);
    chk("tiro_ciclos", ciclos, BASE + 29);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
